// File: rtl/nios_system_ocimem_pkg.sv
// Shared OCI RAM arbiter definitions.
// FSM states, default widths and jdo field positions.
package nios_system_ocimem_pkg;

  localparam int OCI_ADDR_W = 8;
  localparam int OCI_DATA_W = 32;

  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_W   = 32;

  localparam logic GNT_AVS  = 1'b0;
  localparam logic GNT_JTAG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RD_DATA = 2'd2
  } oci_state_t;

endpackage

// File: rtl/nios_system_ocimem_jtag_cmd.sv
// JTAG command capture for the OCI RAM arbiter.
// Holds one request, tracks the address and flags drops.
module nios_system_ocimem_jtag_cmd
  import nios_system_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic              grant,
  input  logic              complete,
  output logic              pending,
  output logic              req_write,
  output logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] jtag_addr,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  logic                  active;
  logic                  any_pulse;
  logic                  accept;
  logic [ADDR_W-1:0]     jdo_addr;
  logic [JDO_DATA_W-1:0] jdo_data;
  logic                  jdo_unused;

  assign any_pulse = take_action_ocimem_a
                   | take_action_ocimem_b
                   | take_no_action_ocimem_a;
  assign accept    = any_pulse & ~pending & ~active;
  assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data  = jdo[JDO_DATA_LSB +: JDO_DATA_W];
  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  // Request slot: pending until granted, active until complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending   <= 1'b0;
      active    <= 1'b0;
      req_write <= 1'b0;
      req_wdata <= '0;
    end else if (accept) begin
      pending   <= 1'b1;
      req_write <= take_action_ocimem_b;
      if (take_action_ocimem_b)
        req_wdata <= DATA_W'(jdo_data);
    end else if (grant) begin
      pending <= 1'b0;
      active  <= 1'b1;
    end else if (complete) begin
      active <= 1'b0;
    end
  end

  // Address: loaded by ocimem_a, post-incremented on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      jtag_addr <= '0;
    else if (accept & take_action_ocimem_a & ~take_action_ocimem_b)
      jtag_addr <= jdo_addr;
    else if (complete)
      jtag_addr <= jtag_addr + ADDR_W'(1);
  end

  // Ready drops after capture and returns after completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      monitor_ready <= 1'b1;
    else if (accept)
      monitor_ready <= 1'b0;
    else if (complete)
      monitor_ready <= 1'b1;
  end

  // Sticky flag for pulses that found the slot occupied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      jtag_overrun <= 1'b0;
    else if (any_pulse & ~accept)
      jtag_overrun <= 1'b1;
  end

endmodule

// File: rtl/nios_system_ocimem_arbiter.sv
// OCI RAM arbiter between JTAG debug and an Avalon slave.
// Round-robin grant, single-port RAM with 1-cycle read.
module nios_system_ocimem_arbiter
  import nios_system_ocimem_pkg::*;
#(
  parameter int ADDR_W = OCI_ADDR_W,
  parameter int DATA_W = OCI_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

  oci_state_t        state;
  logic              last_grant;
  logic              cur_jtag;
  logic              cur_rd;
  logic              avs_req;
  logic              j_pending;
  logic              j_write;
  logic [DATA_W-1:0] j_wdata;
  logic [ADDR_W-1:0] j_addr;
  logic              gnt_jtag;
  logic              gnt_avs;
  logic              j_grant;
  logic              j_complete;
  logic              avs_done;
  logic              finishing;

  nios_system_ocimem_jtag_cmd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_cmd (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .grant                   (j_grant),
    .complete                (j_complete),
    .pending                 (j_pending),
    .req_write               (j_write),
    .req_wdata               (j_wdata),
    .jtag_addr               (j_addr),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  assign avs_req  = avs_read | avs_write;
  assign gnt_jtag = j_pending & (~avs_req | (last_grant == GNT_AVS));
  assign gnt_avs  = avs_req & ~gnt_jtag;
  assign j_grant  = (state == ST_IDLE) & gnt_jtag;

  assign finishing = ((state == ST_ACCESS) & ~cur_rd)
                   | (state == ST_RD_DATA);
  assign j_complete = finishing & cur_jtag;
  assign avs_done   = finishing & ~cur_jtag;

  assign avs_waitrequest = avs_req & ~avs_done;
  assign avs_readdata = ((state == ST_RD_DATA) & ~cur_jtag)
                      ? ram_q : '0;

  // Grant in IDLE, drive RAM during ACCESS, wait a cycle on reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= GNT_AVS;
      cur_jtag   <= 1'b0;
      cur_rd     <= 1'b0;
      ram_addr   <= '0;
      ram_wren   <= 1'b0;
      ram_wdata  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt_jtag) begin
            state      <= ST_ACCESS;
            last_grant <= GNT_JTAG;
            cur_jtag   <= 1'b1;
            cur_rd     <= ~j_write;
            ram_addr   <= j_addr;
            ram_wren   <= j_write;
            ram_wdata  <= j_wdata;
          end else if (gnt_avs) begin
            state      <= ST_ACCESS;
            last_grant <= GNT_AVS;
            cur_jtag   <= 1'b0;
            cur_rd     <= ~avs_write;
            ram_addr   <= avs_address;
            ram_wren   <= avs_write;
            ram_wdata  <= avs_writedata;
          end
        end
        ST_ACCESS: begin
          ram_wren <= 1'b0;
          state    <= cur_rd ? ST_RD_DATA : ST_IDLE;
        end
        ST_RD_DATA: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // JTAG read data is latched as RD_DATA ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      MonDReg <= '0;
    else if ((state == ST_RD_DATA) & cur_jtag)
      MonDReg <= 32'(ram_q);
  end

endmodule

// File: tb/tb_nios_system_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter.
// Includes a 1-cycle-latency RAM model.
module tb_nios_system_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        ta_a, ta_b, tn_a;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [31:0] ram_wdata, ram_q;

  logic [31:0] mem [256];
  logic        mem_init;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_system_ocimem_arbiter dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_wdata               (ram_wdata),
    .ram_q                   (ram_q)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + i;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] ja(input logic [7:0] a);
    logic [37:0] r;
    r = '0;
    r[17:10] = a;
    return r;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] r;
    r = '0;
    r[34:3] = d;
    return r;
  endfunction

  task automatic jtag_op(input logic a, input logic b, input logic n,
                         input logic [37:0] d, input int exp_w,
                         input string tag);
    int w;
    @(posedge clk); #1;
    ta_a = a; ta_b = b; tn_a = n; jdo = d;
    @(posedge clk); #1;
    ta_a = 0; ta_b = 0; tn_a = 0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(monitor_ready), 32'd0);
    w = 1;
    for (int k = 0; k < 20 && !monitor_ready; k++) begin
      @(negedge clk);
      if (!monitor_ready) w++;
    end
    check({tag, "_wait"}, w, exp_w);
  endtask

  task automatic avs_op(input logic rd, input logic wr,
                        input logic [7:0] a, input logic [31:0] wd,
                        output int cnt, output logic [31:0] rdata);
    @(posedge clk); #1;
    avs_read = rd; avs_write = wr;
    avs_address = a; avs_writedata = wd;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      cnt++;
    end
    rdata = avs_readdata;
    @(posedge clk); #1;
    avs_read = 0; avs_write = 0;
  endtask

  task automatic tie_op(input logic [31:0] d, output int cnt,
                        output logic [31:0] rdata);
    @(posedge clk); #1;
    ta_b = 1; jdo = jb(d);
    @(posedge clk); #1;
    ta_b = 0;
    avs_read = 1; avs_address = 8'h20;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      cnt++;
    end
    rdata = avs_readdata;
    @(posedge clk); #1;
    avs_read = 0;
  endtask

  initial begin
    int          cnt;
    logic [31:0] rd;
    reset_n = 0; mem_init = 1;
    jdo = '0; ta_a = 0; ta_b = 0; tn_a = 0;
    avs_address = '0; avs_read = 0; avs_write = 0;
    avs_writedata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(monitor_ready), 32'd1);
    check("rst_mond", MonDReg, 32'd0);
    check("rst_ovr", 32'(jtag_overrun), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_raddr", 32'(ram_addr), 32'd0);
    check("rst_wdata", ram_wdata, 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_wait", 32'(avs_waitrequest), 32'd0);
    @(posedge clk); #1;
    mem_init = 0; reset_n = 1;

    jtag_op(1, 0, 0, ja(8'h10), 3, "rd10");
    check("rd10_mond", MonDReg, 32'hDEADBEEF);
    jtag_op(0, 0, 1, '0, 3, "rd11");
    check("rd11_mond", MonDReg, 32'h1000_0011);

    avs_op(0, 1, 8'h20, 32'h1234_5678, cnt, rd);
    check("aw_lat", cnt, 1);
    check("aw_mem", mem[8'h20], 32'h1234_5678);
    avs_op(1, 0, 8'h20, '0, cnt, rd);
    check("ar_lat", cnt, 2);
    check("ar_data", rd, 32'h1234_5678);

    tie_op(32'h1111_2222, cnt, rd);
    check("tie1_lat", cnt, 4);
    check("tie1_data", rd, 32'h1234_5678);
    check("tie1_mem", mem[8'h12], 32'h1111_2222);
    tie_op(32'h3333_4444, cnt, rd);
    check("tie2_lat", cnt, 4);
    check("tie2_mem", mem[8'h13], 32'h3333_4444);

    jtag_op(1, 0, 0, ja(8'hFE), 3, "rdFE");
    check("rdFE_mond", MonDReg, 32'h1000_00FE);
    jtag_op(0, 1, 0, jb(32'hA5A5_A5A5), 2, "wrFF");
    check("wrFF_mem", mem[8'hFF], 32'hA5A5_A5A5);
    check("wrFF_mond", MonDReg, 32'h1000_00FE);
    jtag_op(0, 0, 1, '0, 3, "rd00");
    check("wrap_mond", MonDReg, 32'h1000_0000);

    jtag_op(1, 1, 1, jb(32'hCAFE_0000), 2, "prio");
    check("prio_mem", mem[8'h01], 32'hCAFE_0000);
    check("prio_ovr", 32'(jtag_overrun), 32'd0);

    @(posedge clk); #1;
    ta_b = 1; jdo = jb(32'h7777_8888);
    @(posedge clk); #1;
    jdo = jb(32'h9999_AAAA);
    @(posedge clk); #1;
    ta_b = 0;
    for (int k = 0; k < 20 && !monitor_ready; k++)
      @(negedge clk);
    check("ovr_ready", 32'(monitor_ready), 32'd1);
    check("ovr_mem1", mem[8'h02], 32'h7777_8888);
    check("ovr_mem2", mem[8'h03], 32'h1000_0003);
    check("ovr_flag", 32'(jtag_overrun), 32'd1);

    @(posedge clk); #1;
    ta_b = 1; jdo = jb(32'hBBBB_CCCC);
    @(posedge clk); #1;
    ta_b = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_wren", 32'(ram_wren), 32'd1);
    check("mid_raddr", 32'(ram_addr), 32'h03);
    #1 reset_n = 0;
    #1;
    check("ar_wren", 32'(ram_wren), 32'd0);
    check("ar_ready", 32'(monitor_ready), 32'd1);
    check("ar_ovr", 32'(jtag_overrun), 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    check("ar_mem", mem[8'h03], 32'h1000_0003);
    jtag_op(0, 0, 1, '0, 3, "ar_rd");
    check("ar_addr0", MonDReg, 32'h1000_0000);
    avs_op(0, 1, 8'h50, 32'h5555_AAAA, cnt, rd);
    check("ar_idle", cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
